// File: rtl/stream_downsize.sv
// stream_downsize: wide-to-narrow stream converter; kept lanes leave one per cycle in ascending lane order
// Ports: clk, rst (synchronous, active-high)
//        s_data_i/s_keep_i/s_last_i/s_valid_i -> s_ready_o : wide beat in, lane 0 first
//        m_data_o/m_last_o/m_valid_o <- m_ready_i          : narrow word out
// Optional macro STREAM_DOWNSIZE_SKID_EN adds a one-beat input skid buffer and makes s_ready_o register-driven.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);
    localparam int IW = $clog2(T_DATA_RATIO);
    localparam logic [T_DATA_RATIO-1:0] ONE = {{(T_DATA_RATIO-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
    logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] mask_q, mask_d;
    logic                    last_q, last_d;
    logic [IW-1:0]           idx;
    logic                    one_left, m_fire, hold_free, load;
    logic [T_DATA_WIDTH-1:0] src_data [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] src_keep;
    logic                    src_last, src_v;

    // priority encoder: lowest remaining lane wins
    always_comb begin
        idx = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--)
            if (mask_q[i]) idx = IW'(i);
    end

    // clearing the lowest set bit leaves zero only when a single lane remains
    assign one_left  = ((mask_q & (mask_q - ONE)) == '0);
    assign m_valid_o = !rst && state_q == SEND;
    assign m_data_o  = m_valid_o ? data_q[idx] : '0;
    assign m_last_o  = m_valid_o && last_q && one_left;
    assign m_fire    = m_valid_o && m_ready_i;
    assign hold_free = state_q == IDLE || (m_fire && one_left);
    assign load      = src_v && hold_free;

`ifdef STREAM_DOWNSIZE_SKID_EN
    logic [T_DATA_WIDTH-1:0] skid_data_q [T_DATA_RATIO-1:0];
    logic [T_DATA_WIDTH-1:0] skid_data_d [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] skid_keep_q, skid_keep_d;
    logic                    skid_last_q, skid_last_d;
    logic                    skid_v_q, skid_v_d;

    assign s_ready_o = !rst && !skid_v_q;
    assign src_v     = skid_v_q || (s_valid_i && s_ready_o);

    // a full skid always feeds the holding stage first; an empty skid is bypassed
    always_comb begin
        src_data    = s_data_i;
        src_keep    = s_keep_i;
        src_last    = s_last_i;
        skid_data_d = skid_data_q;
        skid_keep_d = skid_keep_q;
        skid_last_d = skid_last_q;
        skid_v_d    = skid_v_q;
        if (skid_v_q) begin
            src_data = skid_data_q;
            src_keep = skid_keep_q;
            src_last = skid_last_q;
            skid_v_d = !hold_free;
        end else if (s_valid_i && s_ready_o && !hold_free) begin
            skid_v_d    = 1'b1;
            skid_data_d = s_data_i;
            skid_keep_d = s_keep_i;
            skid_last_d = s_last_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_v_q    <= 1'b0;
            skid_data_q <= '{default: '0};
            skid_keep_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_keep_q <= skid_keep_d;
            skid_last_q <= skid_last_d;
        end
    end
`else
    assign s_ready_o = !rst && hold_free;
    assign src_data  = s_data_i;
    assign src_keep  = s_keep_i;
    assign src_last  = s_last_i;
    assign src_v     = s_valid_i;
`endif

    always_comb begin
        data_d = data_q;
        mask_d = m_fire ? (mask_q & (mask_q - ONE)) : mask_q;
        last_d = last_q;
        if (load) begin
            data_d = src_data;
            mask_d = src_keep;
            last_d = src_last;
        end
        state_d = (mask_d != '0) ? SEND : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '{default: '0};
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_stream_downsize.sv
// tb_stream_downsize: table vectors plus scoreboard-checked corner sequences for stream_downsize
module tb_stream_downsize;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data [3:0];
    logic [3:0] s_keep;
    logic       s_last, s_valid, s_ready_o;
    logic [7:0] m_data_o;
    logic       m_last_o, m_valid_o, m_ready;

    typedef struct packed { logic [7:0] d; logic l; logic f; } exp_t;
    typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; logic [7:0] f; int n; } vec_t;

    exp_t q[$];
    int   out_cyc[$];
    vec_t vecs [6];
    int   n_checks = 0, n_fail = 0, n_out = 0, cyc = 0;
    logic       stall_v = 1'b0, stall_l;
    logic [7:0] stall_d;

    stream_downsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut (
        .clk(clk), .rst(rst),
        .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
        .s_valid_i(s_valid), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor and scoreboard: expected words pushed on wide handshake, popped on narrow handshake
    always @(negedge clk) begin
        exp_t e;
        int   hi;
        logic fin;
        if (rst) begin
            q.delete();
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", m_valid_o, 1);
                chk("stall_data", m_data_o, stall_d);
                chk("stall_last", m_last_o, stall_l);
            end
            fin = q.size() > 0 && q[0].f;
`ifndef STREAM_DOWNSIZE_SKID_EN
            chk("s_ready", s_ready_o, m_valid_o ? (m_ready && fin) : 1'b1);
`endif
            if (m_valid_o && m_ready) begin
                if (q.size() == 0) chk("unexpected_word", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("m_data", m_data_o, e.d);
                    chk("m_last", m_last_o, e.l);
                end
                out_cyc.push_back(cyc);
                n_out++;
            end
            stall_v = m_valid_o && !m_ready;
            stall_d = m_data_o;
            stall_l = m_last_o;
            if (s_valid && s_ready_o) begin
                hi = -1;
                for (int i = 0; i < 4; i++) if (s_keep[i]) hi = i;
                for (int i = 0; i < 4; i++)
                    if (s_keep[i]) q.push_back('{d: s_data[i], l: s_last && i == hi, f: i == hi});
            end
        end
    end

    // holds the beat until accepted; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int waits);
        for (int j = 0; j < 4; j++) s_data[j] = d[8*j +: 8];
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
        waits   = 0;
        @(negedge clk);
        while (!s_ready_o && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!s_ready_o) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, n0;
        vecs[0] = '{32'h44332211, 4'b1111, 1'b1, 8'h11, 4};
        vecs[1] = '{32'h00CC00AA, 4'b0101, 1'b1, 8'hAA, 2};
        vecs[2] = '{32'h5A000000, 4'b1000, 1'b0, 8'h5A, 1};
        vecs[3] = '{32'hFFFFFFFF, 4'b0000, 1'b1, 8'h00, 0};
        vecs[4] = '{32'h00B2B100, 4'b0110, 1'b1, 8'hB1, 2};
        vecs[5] = '{32'hD4D3D2D1, 4'b1110, 1'b0, 8'hD2, 3};
        rst = 1'b1; s_valid = 1'b0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
        s_data = '{default: 8'h00};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_m_data", m_data_o, 0);
        chk("rst_m_last", m_last_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready_o, 1);
        chk("post_rst_m_valid", m_valid_o, 0);
        idle_cycles(1);

        for (int i = 0; i < 6; i++) begin
            n0 = n_out;
            send(vecs[i].d, vecs[i].k, vecs[i].l, w);
            @(negedge clk);
            chk("lat_valid", m_valid_o, vecs[i].k != 0);
            if (vecs[i].k != 0) chk("lat_data", m_data_o, vecs[i].f);
            idle_cycles(6);
            chk("word_count", n_out - n0, vecs[i].n);
        end

        // back-to-back full beats: eight words with no bubble
        out_cyc.delete();
        send(32'h04030201, 4'hF, 1'b1, w);
        send(32'h08070605, 4'hF, 1'b1, w);
`ifdef STREAM_DOWNSIZE_SKID_EN
        chk("b2b_wait", w, 0);
`else
        chk("b2b_wait", w, 3);
`endif
        @(negedge clk);
        chk("b2b_s_ready_low", s_ready_o, 0);
        idle_cycles(10);
        chk("b2b_words", out_cyc.size(), 8);
        if (out_cyc.size() == 8) chk("b2b_span", out_cyc[7] - out_cyc[0], 7);

        // backpressure mid-beat for three cycles
        send(32'hA4A3A2A1, 4'hF, 1'b1, w);
        @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", m_data_o, 8'hA2);
            chk("bp_last", m_last_o, 0);
`ifndef STREAM_DOWNSIZE_SKID_EN
            chk("bp_s_ready", s_ready_o, 0);
`endif
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        idle_cycles(8);

        // zero-keep beat between two full beats
        n0 = n_out;
        send(32'h14131211, 4'hF, 1'b1, w);
        send(32'h99999999, 4'h0, 1'b0, w);
        send(32'h24232221, 4'hF, 1'b1, w);
        idle_cycles(10);
        chk("zk_count", n_out - n0, 8);

        // reset after two of four words
        send(32'hC4C3C2C1, 4'hF, 1'b1, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid_o, 0);
        chk("mid_rst_s_ready", s_ready_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_m_valid", m_valid_o, 0);
        chk("after_rst_s_ready", s_ready_o, 1);
        idle_cycles(1);
        n0 = n_out;
        send(32'hE4E3E2E1, 4'hF, 1'b1, w);
        @(negedge clk);
        chk("after_rst_lane0", m_data_o, 8'hE1);
        idle_cycles(8);
        chk("after_rst_count", n_out - n0, 4);

        chk("sb_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
